// File: rtl/prog_launcher_pkg.sv
// Shared types and constants for the program launcher.
package prog_launcher_pkg;

    typedef enum logic [2:0] {
        L_IDLE,
        L_LAUNCH,
        L_RUN,
        L_REPORT,
        L_FINISH
    } launcher_state_t;

    // Entry address of program 0; the core jumps here when Start is released.
    localparam int unsigned PROG_BASE = 4;

    // States in which a batch is in flight and new Go requests are ignored.
    function automatic logic isBusyState(input launcher_state_t s);
        return (s == L_LAUNCH) || (s == L_RUN) || (s == L_REPORT);
    endfunction

endpackage

// File: rtl/prog_launcher_if.sv
// Host/core handshake bundle of the program launcher.
//
// Handshake: Go is a level request sampled only while the launcher is not
// Busy (IDLE or FINISH); Go while Busy is dropped, never queued. Start is a
// registered level to the core, high for the hold window of each launch.
// Done is the core's halt level, sampled only in RUN. CountValid is a
// one-cycle strobe that qualifies CycleCount; AllDone and TimedOut are levels
// held until the next accepted Go.
interface prog_launcher_if #(
    parameter int NUM_PROGS = 3,
    parameter int CNT_W     = 16
) ();
    localparam int IDX_W = $clog2(NUM_PROGS) + 1;

    logic             Go;
    logic             Done;
    logic             Start;
    logic [IDX_W-1:0] ProgIdx;
    logic             Busy;
    logic [CNT_W-1:0] CycleCount;
    logic             CountValid;
    logic             TimedOut;
    logic             AllDone;

    modport master (
        input  Go, Done,
        output Start, ProgIdx, Busy, CycleCount, CountValid, TimedOut, AllDone
    );

    modport slave (
        output Go, Done,
        input  Start, ProgIdx, Busy, CycleCount, CountValid, TimedOut, AllDone
    );
endinterface

// File: rtl/prog_launcher_cycle_timer.sv
// Clearable up-counter with a "this is the limit-th cycle" flag.
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         hitLimit
);
    localparam logic [W-1:0] INC      = W'(1);
    localparam logic [W:0]   INC_WIDE = (W + 1)'(1);

    // Count enabled cycles; clear has priority so a new phase starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + INC;
        end
    end

    // High on the cycle whose 1-based index equals limit; widened so it never wraps.
    assign hitLimit = (({1'b0, count} + INC_WIDE) == {1'b0, limit});
endmodule

// File: rtl/prog_launcher.sv
// Start/Done sequencer: launches programs back to back, times each one and
// aborts the batch on a hang.
module prog_launcher
    import prog_launcher_pkg::*;
#(
    parameter int NUM_PROGS  = 3,
    parameter int START_HOLD = 2,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    prog_launcher_if.master   bus,
    output launcher_state_t   DbgState
);
    localparam int IDX_W = $clog2(NUM_PROGS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PROGS - 1);
    localparam logic [IDX_W-1:0] IDX_INC   = IDX_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_C    = CNT_W'(START_HOLD);
    localparam logic [CNT_W-1:0] CNT_INC   = CNT_W'(1);

    if (CNT_W < $clog2(TIMEOUT + 1)) begin : g_cnt_w_check
        $error("prog_launcher: CNT_W too narrow to hold TIMEOUT");
    end
    if (CNT_W < $clog2(START_HOLD + 1)) begin : g_hold_w_check
        $error("prog_launcher: CNT_W too narrow to hold START_HOLD");
    end
    if (NUM_PROGS < 1 || START_HOLD < 1) begin : g_param_check
        $error("prog_launcher: NUM_PROGS and START_HOLD must be at least 1");
    end

    launcher_state_t  state, nextState;
    logic [CNT_W-1:0] timerCount;
    logic [CNT_W-1:0] timerLimit;
    logic             timerHit, timerClear, timerEnable;
    logic             holdDone;

    logic             nStart, nBusy, nCountValid, nTimedOut, nAllDone;
    logic [IDX_W-1:0] nProgIdx;
    logic [CNT_W-1:0] nCycleCount;

    // LAUNCH and RUN never overlap, so one timer serves both the Start hold
    // window and the RUN/timeout count; it restarts on every state change.
    assign timerLimit  = (state == L_LAUNCH) ? HOLD_C : TIMEOUT_C;
    assign timerEnable = ((state == L_LAUNCH) && bus.Start) || (state == L_RUN);
    assign timerClear  = (nextState != state);
    assign holdDone    = bus.Start && timerHit;

    cycle_timer #(.W(CNT_W)) u_timer (
        .clk      (Clk),
        .rst      (Reset),
        .clear    (timerClear),
        .enable   (timerEnable),
        .limit    (timerLimit),
        .count    (timerCount),
        .hitLimit (timerHit)
    );

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= L_IDLE;
        else       state <= nextState;
    end

    // Next-state logic; Done beats the timeout when both land on one cycle.
    always_comb begin
        nextState = state;
        case (state)
            L_IDLE, L_FINISH: if (bus.Go) nextState = L_LAUNCH;
            L_LAUNCH:         if (holdDone) nextState = L_RUN;
            L_RUN:            if (bus.Done || timerHit) nextState = L_REPORT;
            L_REPORT:         nextState = (bus.TimedOut || bus.ProgIdx == LAST_IDX)
                                          ? L_FINISH : L_LAUNCH;
            default:          nextState = L_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        nStart      = 1'b0;
        nProgIdx    = bus.ProgIdx;
        nCycleCount = bus.CycleCount;
        nTimedOut   = bus.TimedOut;
        nBusy       = isBusyState(nextState);
        nAllDone    = (nextState == L_FINISH);
        nCountValid = (state == L_RUN) && (nextState == L_REPORT);
        case (state)
            L_IDLE, L_FINISH: begin
                if (bus.Go) begin
                    nProgIdx  = '0;
                    nTimedOut = 1'b0;
                end
            end
            L_LAUNCH: nStart = !holdDone;
            L_RUN: begin
                if (bus.Done) begin
                    nCycleCount = timerCount + CNT_INC;
                end else if (timerHit) begin
                    nCycleCount = TIMEOUT_C;
                    nTimedOut   = 1'b1;
                end
            end
            L_REPORT: if (nextState == L_LAUNCH) nProgIdx = bus.ProgIdx + IDX_INC;
            default: ;
        endcase
    end

    // Output registers; reset clears them asynchronously so Start drops at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.Start      <= 1'b0;
            bus.ProgIdx    <= '0;
            bus.Busy       <= 1'b0;
            bus.CycleCount <= '0;
            bus.CountValid <= 1'b0;
            bus.TimedOut   <= 1'b0;
            bus.AllDone    <= 1'b0;
        end else begin
            bus.Start      <= nStart;
            bus.ProgIdx    <= nProgIdx;
            bus.Busy       <= nBusy;
            bus.CycleCount <= nCycleCount;
            bus.CountValid <= nCountValid;
            bus.TimedOut   <= nTimedOut;
            bus.AllDone    <= nAllDone;
        end
    end

    assign DbgState = state;
endmodule
